// File: rtl/serial_deser.sv
// serial_deser: receive side of the bit-serial link.
// Rebuilds MSB-first bytes from a gated bit stream, packs four bytes per
// 32-bit word (first byte in [7:0]) and writes words to a RAM port whose
// byte address advances by 4 and wraps modulo 2^ADDR_W.
//
// Ports:
//   clk           block clock, one bit per cycle
//   rst           synchronous active-high reset
//   arm_in        one-cycle pulse: clear counters/flags, wait for a frame
//   length_in     expected byte count (sampled on arm_in), 0 = unchecked
//   bit_in        serial data bit
//   bit_valid_in  frame gate, one bit per cycle while high
//   ram_wr_o      one-cycle word write strobe
//   ram_addr_o    4-byte aligned byte address of the write
//   ram_data_o    packed write word
//   byte_cnt_o    bytes accepted this frame (saturates at 511)
//   busy_o        high in WAIT, RECV, FLUSH
//   done_o        one-cycle end-of-frame pulse
//   len_err_o     sticky: accepted byte count differs from length_in
//   bit_err_o     sticky: frame ended with 1-7 leftover bits
//   ovf_err_o     sticky: write address wrapped
module serial_deser #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm_in,
    input  logic [7:0]        length_in,
    input  logic              bit_in,
    input  logic              bit_valid_in,
    output logic              ram_wr_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_data_o,
    output logic [8:0]        byte_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              len_err_o,
    output logic              bit_err_o,
    output logic              ovf_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RECV,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_r;
    logic [6:0]        shift_r;
    logic [2:0]        bit_cnt;
    logic [1:0]        lane_cnt;
    logic [31:0]       word_r;
    logic [7:0]        length_r;
    logic              wr_pend;

    logic              shift_en;
    logic              frame_end;
    logic              byte_ok;
    logic              flush_wr;
    logic [7:0]        byte_nxt;

    function automatic logic [8:0] sat_inc9(input logic [8:0] v);
        return (v == 9'd511) ? v : v + 9'd1;
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] w,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_WAIT:  if (bit_valid_in) state_nxt = S_RECV;
            S_RECV:  if (!bit_valid_in) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // A re-arm wins over whatever the frame was doing.
        if (arm_in) state_nxt = S_WAIT;
    end

    always_comb begin
        byte_nxt  = {shift_r, bit_in};
        shift_en  = !arm_in && bit_valid_in && (state == S_WAIT || state == S_RECV);
        frame_end = !arm_in && !bit_valid_in && (state == S_RECV);
        byte_ok   = (length_r == 8'd0) || (byte_cnt_o < {1'b0, length_r});
        // Partial word left at frame end; lands on the port in the FLUSH
        // cycle, the same cycle a lane-3 write from the last bit would.
        flush_wr  = frame_end && (lane_cnt != 2'd0);
        busy_o    = (state == S_WAIT) || (state == S_RECV) || (state == S_FLUSH);
        done_o    = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r     <= '0;
            shift_r    <= '0;
            bit_cnt    <= '0;
            lane_cnt   <= '0;
            word_r     <= '0;
            length_r   <= '0;
            wr_pend    <= 1'b0;
            ram_wr_o   <= 1'b0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
            byte_cnt_o <= '0;
            len_err_o  <= 1'b0;
            bit_err_o  <= 1'b0;
            ovf_err_o  <= 1'b0;
        end else if (arm_in) begin
            addr_r     <= '0;
            shift_r    <= '0;
            bit_cnt    <= '0;
            lane_cnt   <= '0;
            word_r     <= '0;
            length_r   <= length_in;
            wr_pend    <= 1'b0;
            ram_wr_o   <= 1'b0;
            byte_cnt_o <= '0;
            len_err_o  <= 1'b0;
            bit_err_o  <= 1'b0;
            ovf_err_o  <= 1'b0;
        end else begin
            ram_wr_o <= 1'b0;
            // stage p0: bit shift / byte completion / lane fill
            if (shift_en) begin
                if (bit_cnt == 3'd7) begin
                    shift_r <= '0;
                    bit_cnt <= '0;
                    if (byte_ok) begin
                        word_r     <= lane_put(word_r, lane_cnt, byte_nxt);
                        lane_cnt   <= lane_cnt + 2'd1;
                        byte_cnt_o <= sat_inc9(byte_cnt_o);
                        wr_pend    <= (lane_cnt == 2'd3);
                    end else begin
                        len_err_o <= 1'b1;
                    end
                end else begin
                    shift_r <= byte_nxt[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
            if (frame_end) begin
                shift_r <= '0;
                bit_cnt <= '0;
                if (bit_cnt != 3'd0) bit_err_o <= 1'b1;
                if (length_r != 8'd0 && byte_cnt_o < {1'b0, length_r}) len_err_o <= 1'b1;
            end
            // stage p1: word write to RAM port
            if (wr_pend || flush_wr) begin
                ram_wr_o   <= 1'b1;
                ram_addr_o <= addr_r;
                ram_data_o <= word_r;
                word_r     <= '0;
                lane_cnt   <= '0;
                wr_pend    <= 1'b0;
                addr_r     <= addr_r + ADDR_STEP;
                if (addr_r == ADDR_LAST) ovf_err_o <= 1'b1;
            end
        end
    end

endmodule
